// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scan FSM state type, the matrix size and the key map.
// Helpers: lowest-index low row finder and active-low column drive.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DB_PRESS,
      HELD,
      DB_RELEASE
   } scan_state_t;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   // [row][col] -> hex code printed on the key cap
   localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Lowest-index low row wins when several rows are low together.
   function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (!r[i]) idx = i[1:0];
      end
      return idx;
   endfunction

   // Exactly one column driven low.
   function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
      return ~(4'b0001 << c);
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and its neighbours.
// master: scanner side (reads rows, drives cols and key outputs).
// slave: pad/consumer side (drives rows, observes cols and key outputs).
interface keypad_scanner_if;
   logic [3:0] rows;       // active-low row pins, asynchronous
   logic [3:0] cols;       // active-low column drive, one bit low
   logic [3:0] key_code;   // last accepted key
   logic       key_valid;  // one-cycle pulse per accepted press
   logic       key_held;   // press accepted, release not yet accepted

   modport master (input rows, output cols, key_code, key_valid, key_held);
   modport slave  (output rows, input cols, key_code, key_valid, key_held);
endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles; no backpressure (free-running).
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, hex key code out.
// Latency: pin low -> key_valid = 2 + remaining settle + DEBOUNCE_CYCLES + 1.
// No backpressure: key_valid is a one-cycle pulse, the consumer must take it.
// Ports: clk, reset (sync, active-high), kp (master: rows in; cols, key_* out).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES   = 8,
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic             clk,
   input  logic             reset,
   keypad_scanner_if.master kp
);

   localparam int MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

   scan_state_t          state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [1:0]           col_idx, col_n;
   logic [1:0]           row_idx, row_n;
   logic [3:0]           code_q, code_n;
   logic                 valid_q, valid_n;
   logic                 held_q, held_n;
   logic [NUM_ROWS-1:0]  rows_s;
   logic                 row_pin;

   sync_2ff #(.WIDTH(NUM_ROWS), .RESET_VAL(4'b1111)) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (kp.rows),
      .q     (rows_s)
   );

   // Only the latched row matters once a key is being tracked; other keys,
   // even in the same column, are ignored until this one is released.
   assign row_pin = rows_s[row_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= SCAN;
         cnt     <= '0;
         col_idx <= 2'd0;
         row_idx <= 2'd0;
         code_q  <= 4'h0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         col_idx <= col_n;
         row_idx <= row_n;
         code_q  <= code_n;
         valid_q <= valid_n;
         held_q  <= held_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      col_n   = col_idx;
      row_n   = row_idx;
      code_n  = code_q;
      valid_n = 1'b0;
      held_n  = held_q;
      case (state)
         SCAN: begin
            if (cnt == SETTLE_LAST) begin
               cnt_n = '0;
               if (rows_s != 4'b1111) begin
                  // col_idx stays put: the column is now held on this key
                  row_n   = first_low_row(rows_s);
                  state_n = DB_PRESS;
               end else begin
                  col_n = col_idx + 2'd1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DB_PRESS: begin
            if (row_pin) begin
               state_n = SCAN;
               cnt_n   = '0;
               col_n   = col_idx + 2'd1;
            end else if (cnt == DB_LAST) begin
               valid_n = 1'b1;
               code_n  = KEY_MAP[row_idx][col_idx];
               held_n  = 1'b1;
               cnt_n   = '0;
               state_n = HELD;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         HELD: begin
            if (row_pin) begin
               cnt_n   = '0;
               state_n = DB_RELEASE;
            end
         end
         DB_RELEASE: begin
            if (!row_pin) begin
               // bounce on release: back to held, no new press event
               cnt_n   = '0;
               state_n = HELD;
            end else if (cnt == DB_LAST) begin
               held_n  = 1'b0;
               cnt_n   = '0;
               col_n   = col_idx + 2'd1;
               state_n = SCAN;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = SCAN;
            cnt_n   = '0;
         end
      endcase
   end

   assign kp.cols      = col_drive(col_idx);
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8.
// A pad model pulls a row low while its pressed key's column is driven.
// Ports: none (top-level bench).
module tb_keypad_scanner;

   logic        clk;
   logic        reset;
   logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down

   int          checks;
   int          errors;
   int          pulse_cnt;
   logic [3:0]  codes [$];

   keypad_scanner_if kp();

   keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp)
   );

   function automatic logic [3:0] pad_model(input logic [15:0] p, input logic [3:0] c);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ~|(p[i*4 +: 4] & ~c);
      return r;
   endfunction

   assign kp.rows = pad_model(pressed, kp.cols);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kp.key_valid === 1'b1) begin
         pulse_cnt++;
         codes.push_back(kp.key_code);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (kp.key_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   // Counts cycles with key_held still high; -1 if it never drops.
   task automatic wait_held_low(input int budget, output int h);
      h = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (kp.key_held !== 1'b1) begin
            h = i;
            break;
         end
      end
   endtask

   task automatic wait_cols(input logic [3:0] val, input bit eq, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((kp.cols === val) == eq) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_cols;
      bit         stray;
      reset   = 1'b1;
      pressed = 16'h0;
      repeat (3) tick();
      checks++;
      if (kp.cols !== 4'b1110 || kp.key_code !== 4'h0 || kp.key_valid !== 1'b0 || kp.key_held !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: cols=%b code=%h valid=%b held=%b, need 1110/0/0/0",
                  kp.cols, kp.key_code, kp.key_valid, kp.key_held);
      end
      reset = 1'b0;
      stray = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         tick();
         exp_cols = ~(4'b0001 << ((n / 4) % 4));
         checks++;
         if (kp.cols !== exp_cols) begin
            errors++;
            $display("FAIL scan_step n=%0d: cols=%b, need %b", n, kp.cols, exp_cols);
         end
         if (kp.key_valid !== 1'b0) stray = 1'b1;
      end
      checks++;
      if (stray || kp.key_code !== 4'h0) begin
         errors++;
         $display("FAIL idle_no_key: stray_valid=%b code=%h, need 0/0", stray, kp.key_code);
      end
   endtask

   task automatic test_press_6();
      int p0, lat, h;
      bit ok;
      p0 = pulse_cnt;
      wait_cols(4'b1011, 1'b1, 40, ok);
      pressed[1*4+2] = 1'b1;
      wait_valid(40, lat);
      checks++;
      if (!ok || lat != 12) begin
         errors++;
         $display("FAIL press6_latency: got %0d cycles (col_found=%b), need 12", lat, ok);
      end
      checks++;
      if (kp.key_code !== 4'h6 || kp.key_held !== 1'b1 || kp.cols !== 4'b1011) begin
         errors++;
         $display("FAIL press6_accept: code=%h held=%b cols=%b, need 6/1/1011",
                  kp.key_code, kp.key_held, kp.cols);
      end
      tick();
      checks++;
      if (kp.key_valid !== 1'b0) begin
         errors++;
         $display("FAIL press6_pulse_width: valid=%b one cycle later, need 0", kp.key_valid);
      end
      repeat (50 - 13) tick();
      checks++;
      if (kp.key_held !== 1'b1) begin
         errors++;
         $display("FAIL press6_held: held=%b after 50 cycles pressed, need 1", kp.key_held);
      end
      pressed = 16'h0;
      wait_held_low(40, h);
      checks++;
      if (h != 10) begin
         errors++;
         $display("FAIL press6_release_time: held stayed %0d cycles, need 10", h);
      end
      checks++;
      if (kp.cols !== 4'b0111 || kp.key_code !== 4'h6 || pulse_cnt - p0 != 1) begin
         errors++;
         $display("FAIL press6_after: cols=%b code=%h pulses=%0d, need 0111/6/1",
                  kp.cols, kp.key_code, pulse_cnt - p0);
      end
   endtask

   task automatic test_glitch_e();
      int p0, lat, h;
      bit ok1, ok2;
      p0 = pulse_cnt;
      wait_cols(4'b1110, 1'b0, 40, ok1);
      wait_cols(4'b1110, 1'b1, 40, ok2);
      pressed[3*4+0] = 1'b1;
      repeat (3) tick();
      pressed[3*4+0] = 1'b0;
      tick();
      pressed[3*4+0] = 1'b1;
      repeat (2) tick();
      checks++;
      if (!ok1 || !ok2 || kp.cols !== 4'b1101 || pulse_cnt - p0 != 0 || kp.key_held !== 1'b0) begin
         errors++;
         $display("FAIL glitch_abort: cols=%b pulses=%0d held=%b, need 1101/0/0",
                  kp.cols, pulse_cnt - p0, kp.key_held);
      end
      wait_valid(60, lat);
      checks++;
      if (lat < 0 || kp.key_code !== 4'hE || pulse_cnt - p0 != 1) begin
         errors++;
         $display("FAIL glitch_steady: lat=%0d code=%h pulses=%0d, need code E, 1 pulse",
                  lat, kp.key_code, pulse_cnt - p0);
      end
      pressed = 16'h0;
      wait_held_low(40, h);
      checks++;
      if (h < 0 || pulse_cnt - p0 != 1) begin
         errors++;
         $display("FAIL glitch_release: held_cycles=%0d pulses=%0d, need release and 1 pulse",
                  h, pulse_cnt - p0);
      end
   endtask

   task automatic test_bounce_5();
      int p0, lat, h;
      p0 = pulse_cnt;
      pressed[1*4+1] = 1'b1;
      wait_valid(60, lat);
      checks++;
      if (lat < 0 || kp.key_code !== 4'h5) begin
         errors++;
         $display("FAIL bounce5_press: lat=%0d code=%h, need code 5", lat, kp.key_code);
      end
      repeat (5) tick();
      pressed[1*4+1] = 1'b0;
      repeat (3) tick();
      pressed[1*4+1] = 1'b1;
      repeat (15) tick();
      checks++;
      if (kp.key_held !== 1'b1 || pulse_cnt - p0 != 1) begin
         errors++;
         $display("FAIL bounce5_hold: held=%b pulses=%0d, need 1/1", kp.key_held, pulse_cnt - p0);
      end
      pressed = 16'h0;
      wait_held_low(40, h);
      checks++;
      if (h != 10 || pulse_cnt - p0 != 1) begin
         errors++;
         $display("FAIL bounce5_release: held_cycles=%0d pulses=%0d, need 10/1", h, pulse_cnt - p0);
      end
   endtask

   task automatic test_back_to_back();
      int p0, lat, h;
      p0 = pulse_cnt;
      pressed[0*4+0] = 1'b1;
      wait_valid(60, lat);
      checks++;
      if (lat < 0 || kp.key_code !== 4'h1) begin
         errors++;
         $display("FAIL rollover_first: lat=%0d code=%h, need code 1", lat, kp.key_code);
      end
      pressed[2*4+2] = 1'b1;
      repeat (20) tick();
      checks++;
      if (pulse_cnt - p0 != 1 || kp.key_code !== 4'h1) begin
         errors++;
         $display("FAIL rollover_ignore: pulses=%0d code=%h, need 1/1", pulse_cnt - p0, kp.key_code);
      end
      pressed[0*4+0] = 1'b0;
      wait_valid(80, lat);
      checks++;
      if (lat < 0 || pulse_cnt - p0 != 2 || codes[p0] !== 4'h1 || codes[p0+1] !== 4'h9) begin
         errors++;
         $display("FAIL rollover_order: pulses=%0d, need 2 pulses with codes 1 then 9",
                  pulse_cnt - p0);
      end
      pressed = 16'h0;
      wait_held_low(40, h);
      checks++;
      if (h < 0) begin
         errors++;
         $display("FAIL rollover_release: held never dropped, need drop");
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      bit ok1, ok2;
      p0 = pulse_cnt;
      wait_cols(4'b0111, 1'b0, 40, ok1);
      wait_cols(4'b0111, 1'b1, 40, ok2);
      pressed[0*4+3] = 1'b1;
      repeat (6) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (!ok1 || !ok2 || kp.cols !== 4'b1110 || kp.key_code !== 4'h0 ||
          kp.key_held !== 1'b0 || kp.key_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: cols=%b code=%h held=%b valid=%b, need 1110/0/0/0",
                  kp.cols, kp.key_code, kp.key_held, kp.key_valid);
      end
      pressed = 16'h0;
      reset   = 1'b0;
      repeat (30) tick();
      checks++;
      if (pulse_cnt - p0 != 0 || kp.key_code !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_quiet: pulses=%0d code=%h, need 0/0", pulse_cnt - p0, kp.key_code);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      pulse_cnt = 0;
      reset     = 1'b1;
      pressed   = 16'h0;
      test_reset();
      test_press_6();
      test_glitch_e();
      test_bounce_5();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
